input_capture: RTL and testbench
================================

Name: input_capture

Overview:
- Receive-side counterpart of the sorter's display serializer.
- Deserializes four 4-bit numbers presented one after another on a shared nibble bus. Each number is held for HOLD clock cycles. The block samples each slot at a fixed point and publishes all four values together, with a one-cycle done pulse.
- Sits between the input switches/bus and the sorting core. capture_done starts the sort.

Parameters:
- HOLD, 41, cycles per slot. Slot counter runs 0..HOLD-1; must be >= 2.
- SAMPLE_POINT, 20, cycle within a slot at which part_in is latched; must be < HOLD.
- CNT_W, 16, width of the slot cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start_capture  in  1  request to begin capture; level or pulse.
- part_in  in  4  serial nibble bus; slot 0 carries num0 first, slot 3 carries num3 last.
- num0  out  4  captured value of slot 0.
- num1  out  4  captured value of slot 1.
- num2  out  4  captured value of slot 2.
- num3  out  4  captured value of slot 3.
- busy  out  1  high while a capture is in progress.
- capture_done  out  1  one-cycle pulse; num0..num3 are updated in the same cycle.
- slot_err  out  1  stability error flag; exists only with the optional feature.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, cnt=0, slot=0.
  - All shadow registers and num0..num3 = 0.
  - busy=0, capture_done=0, slot_err=0.
  - Reset has priority over all other events, including mid-capture. A partial capture is discarded and never published.
- States: IDLE, CAPTURE, DONE.
- IDLE:
  - cnt=0, slot=0, busy=0.
  - start_capture=1 at an edge: go to CAPTURE. First CAPTURE cycle has cnt=0, slot=0.
- CAPTURE:
  - busy=1.
  - cnt increments each cycle.
  - When cnt==SAMPLE_POINT: shadow[slot] <= part_in.
  - When cnt==HOLD-1 and slot<3: cnt <= 0, slot <= slot+1.
  - When cnt==HOLD-1 and slot==3: go to DONE.
  - start_capture is ignored while in CAPTURE.
- DONE (one cycle):
  - num0..num3 <= shadow0..3 at the entering edge, so they are visible during DONE.
  - capture_done=1, busy=0.
  - Next state is IDLE unconditionally.
  - start_capture is not accepted in DONE. Minimum gap between captures is one IDLE cycle.
- Latency: start accepted at edge E gives capture_done high in cycle E+4*HOLD+1 (E+165 at defaults).
- Output hold: num outputs stay stable between done pulses. They never change mid-capture.
- Widths: counter compares are done at CNT_W bits; slot is 2 bits and never wraps past 3.
- Simultaneous events: start_capture together with rst resets and stays in IDLE.

Optional Feature:
- Macro: INPUT_CAPTURE_STABLE_CHECK_EN.
- Defined:
  - The block also latches part_in at cnt==0 and at cnt==HOLD-1 of each slot.
  - If either of these differs from the SAMPLE_POINT value, a sticky error bit is set.
  - slot_err <= sticky bit at DONE and holds until the next DONE or rst.
  - The sticky bit clears when CAPTURE is entered.
- Not defined:
  - Port slot_err is absent and no extra registers are built.
  - Behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst for 3 cycles, part_in toggling -> num0..3=0, busy=0, capture_done never high.
- Basic capture: pulse start, drive 4'h3, 4'hA, 4'h0, 4'hF, each for 41 cycles, aligned to slot starts -> capture_done high exactly at cycle E+165, num0..3=3,A,0,F, busy high for 164 cycles.
- Sample point: within slot 1, drive 4'h5 for cnt 0..19 and 4'h9 from cnt 20 on -> num1=9. Under INPUT_CAPTURE_STABLE_CHECK_EN, slot_err=1 at done.
- Start ignored while busy: pulse start again at slot 2 -> exactly one capture_done and latency unchanged. Start held high continuously -> done pulses spaced 4*HOLD+2 cycles apart.
- Mid-capture reset: rst during slot 2 after a prior capture of 1,2,3,4 -> outputs return to 0, no done pulse. A new capture then completes normally.
- Parameter override: HOLD=4, SAMPLE_POINT=1 -> done at E+17 with correct values. Clean held data with the check enabled -> slot_err=0.

Source files
------------

// File: rtl/input_capture.sv
// Nibble-bus deserializer: samples four HOLD-cycle slots and publishes them with a done pulse.
// Optional stability check (slot_err) enabled by defining INPUT_CAPTURE_STABLE_CHECK_EN.
module input_capture #(
  parameter int unsigned HOLD         = 41,
  parameter int unsigned SAMPLE_POINT = 20,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_capture,
  input  logic [3:0] part_in,
  output logic [3:0] num0,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic       busy,
  output logic       capture_done
`ifdef INPUT_CAPTURE_STABLE_CHECK_EN
  ,
  output logic       slot_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] SAMP = CNT_W'(SAMPLE_POINT);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       slot_q;
  logic [3:0]       shadow_q [4];
  logic [3:0]       num_q    [4];
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      slot_q   <= '0;
      shadow_q <= '{default: '0};
      num_q    <= '{default: '0};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_capture) begin
            state_q <= S_CAPTURE;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            slot_q  <= '0;
          end
        end
        S_CAPTURE: begin
          if (cnt_q == SAMP) shadow_q[slot_q] <= part_in;
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (slot_q == 2'd3) begin
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              num_q[0] <= shadow_q[0];
              num_q[1] <= shadow_q[1];
              num_q[2] <= shadow_q[2];
              // slot 3 may be sampled on this very edge when SAMPLE_POINT == HOLD-1
              num_q[3] <= (cnt_q == SAMP) ? part_in : shadow_q[3];
            end else begin
              slot_q <= slot_q + 2'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign num0         = num_q[0];
  assign num1         = num_q[1];
  assign num2         = num_q[2];
  assign num3         = num_q[3];
  assign busy         = busy_q;
  assign capture_done = done_q;

`ifdef INPUT_CAPTURE_STABLE_CHECK_EN
  logic [3:0] first_q;
  logic       err_q;
  logic       slot_err_q;
  logic [3:0] samp_d;
  logic [3:0] first_d;
  logic       mism_d;

  // Forward same-edge samples so SAMPLE_POINT may coincide with cnt 0 or HOLD-1.
  always_comb begin
    samp_d  = (cnt_q == SAMP) ? part_in : shadow_q[slot_q];
    first_d = (cnt_q == '0)   ? part_in : first_q;
    mism_d  = (first_d != samp_d) || (part_in != samp_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q    <= '0;
      err_q      <= 1'b0;
      slot_err_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start_capture) err_q <= 1'b0;
      if (state_q == S_CAPTURE) begin
        if (cnt_q == '0) first_q <= part_in;
        if (cnt_q == LAST) begin
          err_q <= err_q | mism_d;
          if (slot_q == 2'd3) slot_err_q <= err_q | mism_d;
        end
      end
    end
  end

  assign slot_err = slot_err_q;
`endif

endmodule

// File: tb/tb_input_capture.sv
// Self-checking bench for input_capture: table-driven captures checked by a done-pulse scoreboard.
module tb_input_capture;

  localparam int unsigned H   = 41;
  localparam int unsigned SP  = 20;
  localparam int unsigned HS  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1;
  logic [3:0] pin0, pin1;
  logic [3:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic       busy0, done0, busy1, done1;
`ifdef INPUT_CAPTURE_STABLE_CHECK_EN
  logic       err0, err1;
`endif

  input_capture dut (
    .clk(clk), .rst(rst), .start_capture(start0), .part_in(pin0),
    .num0(a0), .num1(a1), .num2(a2), .num3(a3),
    .busy(busy0), .capture_done(done0)
`ifdef INPUT_CAPTURE_STABLE_CHECK_EN
    , .slot_err(err0)
`endif
  );

  input_capture #(.HOLD(HS), .SAMPLE_POINT(1)) dut_s (
    .clk(clk), .rst(rst), .start_capture(start1), .part_in(pin1),
    .num0(b0), .num1(b1), .num2(b2), .num3(b3),
    .busy(busy1), .capture_done(done1)
`ifdef INPUT_CAPTURE_STABLE_CHECK_EN
    , .slot_err(err1)
`endif
  );

  typedef struct {
    logic [15:0] vals;   // slot s value in vals[4*s +: 4]
    logic [15:0] pre;    // value shown before the sample point in glitched slots
    logic [3:0]  gmask;
    logic        pulse;  // extra start pulse during slot 2
    logic        keep;   // hold start high for the whole capture
    logic        err;
  } vec_t;

  typedef struct {
    logic [15:0] nums;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned ntests = 0;
  int unsigned nfail  = 0;
  int unsigned cyc    = 0;
  logic        rst_e  = 1'b1;
  logic        mon_en = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_e <= rst;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  logic [15:0] held_nums = '0;
  logic        held_err  = 1'b0;
  int unsigned busy_run  = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (rst_e) begin
        held_nums = '0;
        held_err  = 1'b0;
        busy_run  = 0;
      end
      if (busy0) busy_run++;
      if (done0) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done0), 32'(0));
        end else begin
          e = q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("nums", 32'({a3, a2, a1, a0}), 32'(e.nums));
          chk("busy_len", 32'(busy_run), 32'(4 * H));
          chk("busy_at_done", 32'(busy0), 32'(0));
`ifdef INPUT_CAPTURE_STABLE_CHECK_EN
          chk("slot_err", 32'(err0), 32'(e.err));
`endif
          held_nums = e.nums;
          held_err  = e.err;
          busy_run  = 0;
        end
      end else begin
        chk("num_hold", 32'({a3, a2, a1, a0}), 32'(held_nums));
`ifdef INPUT_CAPTURE_STABLE_CHECK_EN
        chk("err_hold", 32'(err0), 32'(held_err));
`endif
      end
    end
  end

  task automatic cap(input vec_t v);
    exp_t e;
    int unsigned s, c;
    @(negedge clk);
    start0 = 1'b1;
    e.nums = v.vals;
    e.err  = v.err;
    e.cyc  = cyc + 4 * H + 1;
    q.push_back(e);
    for (int unsigned i = 0; i < 4 * H; i++) begin
      @(negedge clk);
      s = i / H;
      c = i % H;
      start0 = v.keep || (v.pulse && i == 2 * H + 3);
      pin0 = (v.gmask[s] && c < SP) ? v.pre[4*s +: 4] : v.vals[4*s +: 4];
    end
    @(negedge clk);
    pin0 = 4'($urandom_range(15));
  endtask

  vec_t tbl[6];

  initial begin : main
    logic [15:0] sv;
    int unsigned c0;
    bit          got;
    tbl[0] = '{vals: 16'hF0A3, pre: 16'h0000, gmask: 4'b0000, pulse: 1'b0, keep: 1'b0, err: 1'b0};
    tbl[1] = '{vals: 16'h4321, pre: 16'h0000, gmask: 4'b0000, pulse: 1'b0, keep: 1'b0, err: 1'b0};
    tbl[2] = '{vals: 16'h7691, pre: 16'h0050, gmask: 4'b0010, pulse: 1'b0, keep: 1'b0, err: 1'b1};
    tbl[3] = '{vals: 16'hC5A8, pre: 16'h0000, gmask: 4'b0000, pulse: 1'b1, keep: 1'b0, err: 1'b0};
    tbl[4] = '{vals: 16'hEDCB, pre: 16'h0000, gmask: 4'b0000, pulse: 1'b0, keep: 1'b1, err: 1'b0};
    tbl[5] = '{vals: 16'h1F2E, pre: 16'h0000, gmask: 4'b0000, pulse: 1'b0, keep: 1'b0, err: 1'b0};

    // Reset with start held and part_in toggling.
    rst = 1'b1; start0 = 1'b1; start1 = 1'b1; pin0 = 4'h5; pin1 = 4'hA;
    @(negedge clk);
    mon_en = 1'b1;
    for (int unsigned k = 0; k < 2; k++) begin
      @(negedge clk);
      pin0 = ~pin0;
      chk("rst_busy", 32'(busy0), 32'(0));
      chk("rst_done", 32'(done0), 32'(0));
      chk("rst_nums", 32'({a3, a2, a1, a0}), 32'(0));
      chk("rst_busy_s", 32'(busy1), 32'(0));
    end
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", 32'(busy0), 32'(0));
`ifdef INPUT_CAPTURE_STABLE_CHECK_EN
    chk("rst_err", 32'(err0), 32'(0));
`endif

    for (int unsigned k = 0; k < 6; k++) cap(tbl[k]);

    // Mid-capture reset after a completed 1,2,3,4 capture.
    cap(tbl[1]);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (2 * H + 3) begin
      @(negedge clk);
      pin0 = 4'($urandom_range(15));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy0), 32'(0));
    chk("midrst_nums", 32'({a3, a2, a1, a0}), 32'(0));
    repeat (4 * H + 10) @(negedge clk);
    cap(tbl[0]);
    repeat (3) @(negedge clk);

    // Small instance: HOLD=4, SAMPLE_POINT=1.
    sv = 16'h9C63;
    @(negedge clk);
    start1 = 1'b1;
    pin1 = sv[3:0];
    c0 = cyc;
    for (int unsigned i = 0; i < 4 * HS; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      pin1 = sv[4*(i/HS) +: 4];
    end
    got = 1'b0;
    for (int unsigned t = 0; t < 8 && !got; t++) begin
      @(negedge clk);
      if (done1) begin
        got = 1'b1;
        chk("small_done_cycle", 32'(cyc), 32'(c0 + 4 * HS + 1));
        chk("small_nums", 32'({b3, b2, b1, b0}), 32'(sv));
`ifdef INPUT_CAPTURE_STABLE_CHECK_EN
        chk("small_err", 32'(err1), 32'(0));
`endif
      end
    end
    if (!got) chk("small_done_seen", 32'(0), 32'(1));
    repeat (2) @(negedge clk);

    chk("queue_empty", 32'(q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
